fifo_uart_tx_drain: RTL

Downstream consumer for the 8-bit main FIFO. It pops one byte at a time whenever the FIFO is non-empty and draining is enabled, then serializes each byte onto a UART TX line as 8N1 (8 data bits, no parity, 1 stop bit), LSB first. It never reads while fifo_empty is high, so it cannot cause a FIFO underflow. It also keeps a running count of sent bytes for status/debug.

---
 rtl/fifo_uart_tx_drain.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx_drain.sv
// Drains the main FIFO one byte at a time and sends each byte as UART 8N1, LSB first.
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module fifo_uart_tx_drain #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              tx_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done,
    output logic [15:0]       frame_cnt,
    output logic [2:0]        dbg_state_o
);
    localparam int               BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PAR   = 3'd5,
`endif
        STOP  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              busy_q, busy_d;
    logic              byte_done_q, byte_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_en && !fifo_empty) state_d = RD;
            end
            RD: state_d = LOAD;
            LOAD: begin
                // FIFO read data is valid exactly one cycle after the strobe
                shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PAR: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PAR:     tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
        fifo_rd_d   = (state_d == RD);
        busy_d      = (state_d != IDLE);
        byte_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
        frame_cnt_d = byte_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            fifo_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            fifo_rd_q   <= fifo_rd_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign fifo_rd     = fifo_rd_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign byte_done   = byte_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule
